// File: rtl/wb_stage.sv
// Writeback stage: picks ALU / load / PC+4 result and drives a registered register-file write pulse.
// Optional WB_INSTRET_EN adds a 64-bit retired-instruction counter output (instret).
module wb_stage #(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_rd_en,
    input  logic [RADDR_W-1:0] in_rd_addr,
    input  logic [1:0]         in_sel,
    input  logic [XLEN-1:0]    in_alu_result,
    input  logic [XLEN-1:0]    in_pc_plus4,
    input  logic [1:0]         in_load_size,
    input  logic               in_load_unsigned,
    input  logic [1:0]         in_addr_lo,
    input  logic               mem_rvalid,
    input  logic [XLEN-1:0]    mem_rdata,
    output logic               rd_we,
    output logic [RADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]    rd_wdata,
    output logic               err_misalign,
    output logic               err_unexp_rvalid
`ifdef WB_INSTRET_EN
    ,
    output logic [63:0]        instret
`endif
);

    localparam logic [0:0] IDLE      = 1'b0;
    localparam logic [0:0] WAIT_LOAD = 1'b1;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_NONE = 2'b11;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;

    logic [0:0]         state_q, state_d;
    logic               ld_rd_en_q, ld_rd_en_d;
    logic [RADDR_W-1:0] ld_rd_addr_q, ld_rd_addr_d;
    logic [1:0]         ld_size_q, ld_size_d;
    logic               ld_unsigned_q, ld_unsigned_d;
    logic [1:0]         ld_addr_lo_q, ld_addr_lo_d;

    logic               rd_we_d;
    logic [RADDR_W-1:0] rd_addr_d;
    logic [XLEN-1:0]    rd_wdata_d;
    logic               err_misalign_d;
    logic               err_unexp_rvalid_d;

    // Lane select plus sign/zero extension of a little-endian load word.
    function automatic logic [XLEN-1:0] extract(input logic [XLEN-1:0] data,
                                                input logic [1:0]      size,
                                                input logic            uns,
                                                input logic [1:0]      lo);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'd0:    b = data[7:0];
            2'd1:    b = data[15:8];
            2'd2:    b = data[23:16];
            default: b = data[31:24];
        endcase
        h = lo[1] ? data[31:16] : data[15:0];
        case (size)
            SZ_BYTE: extract = {{(XLEN-8){b[7] & ~uns}}, b};
            SZ_HALF: extract = {{(XLEN-16){h[15] & ~uns}}, h};
            default: extract = data;
        endcase
    endfunction

    assign in_ready = (state_q == IDLE);

    // Next-state and next-output logic.
    always_comb begin
        state_d            = state_q;
        ld_rd_en_d         = ld_rd_en_q;
        ld_rd_addr_d       = ld_rd_addr_q;
        ld_size_d          = ld_size_q;
        ld_unsigned_d      = ld_unsigned_q;
        ld_addr_lo_d       = ld_addr_lo_q;
        rd_we_d            = 1'b0;
        rd_addr_d          = rd_addr;
        rd_wdata_d         = rd_wdata;
        err_misalign_d     = err_misalign;
        err_unexp_rvalid_d = err_unexp_rvalid;
        case (state_q)
            IDLE: begin
                if (mem_rvalid) begin
                    err_unexp_rvalid_d = 1'b1;
                end
                if (in_valid) begin
                    if (in_sel == SEL_LOAD) begin
                        state_d       = WAIT_LOAD;
                        ld_rd_en_d    = in_rd_en;
                        ld_rd_addr_d  = in_rd_addr;
                        ld_size_d     = in_load_size;
                        ld_unsigned_d = in_load_unsigned;
                        ld_addr_lo_d  = in_addr_lo;
                        if (in_load_size == SZ_HALF && in_addr_lo[0]) begin
                            err_misalign_d = 1'b1;
                        end
                    end else begin
                        rd_addr_d  = in_rd_addr;
                        rd_wdata_d = (in_sel == SEL_PC4) ? in_pc_plus4 : in_alu_result;
                        rd_we_d    = in_rd_en && (in_rd_addr != '0) && (in_sel != SEL_NONE);
                    end
                end
            end
            WAIT_LOAD: begin
                if (mem_rvalid) begin
                    state_d    = IDLE;
                    rd_addr_d  = ld_rd_addr_q;
                    rd_wdata_d = extract(mem_rdata, ld_size_q, ld_unsigned_q, ld_addr_lo_q);
                    rd_we_d    = ld_rd_en_q && (ld_rd_addr_q != '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q          <= IDLE;
            ld_rd_en_q       <= 1'b0;
            ld_rd_addr_q     <= '0;
            ld_size_q        <= '0;
            ld_unsigned_q    <= 1'b0;
            ld_addr_lo_q     <= '0;
            rd_we            <= 1'b0;
            rd_addr          <= '0;
            rd_wdata         <= '0;
            err_misalign     <= 1'b0;
            err_unexp_rvalid <= 1'b0;
        end else begin
            state_q          <= state_d;
            ld_rd_en_q       <= ld_rd_en_d;
            ld_rd_addr_q     <= ld_rd_addr_d;
            ld_size_q        <= ld_size_d;
            ld_unsigned_q    <= ld_unsigned_d;
            ld_addr_lo_q     <= ld_addr_lo_d;
            rd_we            <= rd_we_d;
            rd_addr          <= rd_addr_d;
            rd_wdata         <= rd_wdata_d;
            err_misalign     <= err_misalign_d;
            err_unexp_rvalid <= err_unexp_rvalid_d;
        end
    end

`ifdef WB_INSTRET_EN
    // One count per completed instruction, whether or not it writes.
    logic retire;
    assign retire = ((state_q == IDLE) && in_valid && (in_sel != SEL_LOAD)) ||
                    ((state_q == WAIT_LOAD) && mem_rvalid);

    always_ff @(posedge clk) begin
        if (!rst) begin
            instret <= 64'd0;
        end else if (retire) begin
            instret <= instret + 64'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed literal cases followed by random traffic
// compared every cycle against a behavioural model of the writeback rules.
module tb_wb_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_rd_en;
    logic [4:0]  in_rd_addr;
    logic [1:0]  in_sel;
    logic [31:0] in_alu_result;
    logic [31:0] in_pc_plus4;
    logic [1:0]  in_load_size;
    logic        in_load_unsigned;
    logic [1:0]  in_addr_lo;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rd_we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_wdata;
    logic        err_misalign;
    logic        err_unexp_rvalid;
`ifdef WB_INSTRET_EN
    logic [63:0] instret;
`endif

    int total = 0;
    int bad   = 0;

    wb_stage dut (
        .clk              (clk),
        .rst              (rst),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_rd_en         (in_rd_en),
        .in_rd_addr       (in_rd_addr),
        .in_sel           (in_sel),
        .in_alu_result    (in_alu_result),
        .in_pc_plus4      (in_pc_plus4),
        .in_load_size     (in_load_size),
        .in_load_unsigned (in_load_unsigned),
        .in_addr_lo       (in_addr_lo),
        .mem_rvalid       (mem_rvalid),
        .mem_rdata        (mem_rdata),
        .rd_we            (rd_we),
        .rd_addr          (rd_addr),
        .rd_wdata         (rd_wdata),
        .err_misalign     (err_misalign),
        .err_unexp_rvalid (err_unexp_rvalid)
`ifdef WB_INSTRET_EN
        ,
        .instret          (instret)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Load value from the architectural rule: shift the addressed lane down, mask, extend.
    function automatic logic [31:0] model_load(input logic [31:0] d, input int size,
                                               input bit uns, input int lo);
        longint v;
        int bits;
        int sh;
        if (size == 0) begin
            bits = 8;  sh = 8 * lo;
        end else if (size == 1) begin
            bits = 16; sh = 16 * (lo / 2);
        end else begin
            bits = 32; sh = 0;
        end
        v = (longint'(d) >> sh) & ((longint'(1) << bits) - 1);
        if (!uns && bits < 32 && v >= (longint'(1) << (bits - 1)))
            v = v - (longint'(1) << bits);
        return v[31:0];
    endfunction

    // Behavioural model: at most one load outstanding, results visible the cycle after completion.
    bit          m_ok = 0;
    bit          m_busy, m_we, m_known, m_mis, m_unexp;
    bit          p_en, p_uns;
    int          p_addr, p_size, p_lo;
    logic [4:0]  m_addr;
    logic [31:0] m_wdata;
    longint      m_cnt;

    always @(posedge clk) begin
        if (!rst) begin
            m_busy = 0; m_we = 0; m_addr = '0; m_wdata = '0;
            m_mis = 0; m_unexp = 0; m_cnt = 0; m_known = 1; m_ok = 1;
        end else if (m_ok) begin
            m_we = 0;
            if (!m_busy) begin
                if (mem_rvalid) m_unexp = 1;
                if (in_valid) begin
                    if (in_sel == 2'd1) begin
                        m_busy = 1;
                        p_en = in_rd_en; p_addr = int'(in_rd_addr);
                        p_size = int'(in_load_size); p_uns = in_load_unsigned;
                        p_lo = int'(in_addr_lo);
                        if (p_size == 1 && (p_lo % 2) == 1) m_mis = 1;
                    end else begin
                        m_we    = in_rd_en && in_rd_addr != 0 && in_sel != 2'd3;
                        m_addr  = in_rd_addr;
                        m_wdata = (in_sel == 2'd2) ? in_pc_plus4 : in_alu_result;
                        m_known = (in_sel != 2'd3);
                        m_cnt++;
                    end
                end
            end else if (mem_rvalid) begin
                m_busy  = 0;
                m_we    = p_en && p_addr != 0;
                m_addr  = 5'(p_addr);
                m_wdata = model_load(mem_rdata, p_size, p_uns, p_lo);
                m_known = 1;
                m_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (m_ok) begin
            check("in_ready", 64'(in_ready), 64'(!m_busy));
            check("rd_we", 64'(rd_we), 64'(m_we));
            if (m_we || m_known) begin
                check("rd_addr", 64'(rd_addr), 64'(m_addr));
                check("rd_wdata", 64'(rd_wdata), 64'(m_wdata));
            end
            check("err_misalign", 64'(err_misalign), 64'(m_mis));
            check("err_unexp_rvalid", 64'(err_unexp_rvalid), 64'(m_unexp));
`ifdef WB_INSTRET_EN
            check("instret", instret, m_cnt);
`endif
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] sel, input logic [4:0] rd, input logic [31:0] val,
                         input logic [1:0] size, input logic uns, input logic [1:0] lo);
        in_valid = 1; in_rd_en = 1; in_sel = sel; in_rd_addr = rd;
        in_alu_result = val; in_pc_plus4 = val;
        in_load_size = size; in_load_unsigned = uns; in_addr_lo = lo;
    endtask

    // Accept a load, wait two idle cycles, then return rdata.
    task automatic do_load(input logic [4:0] rd, input logic [1:0] size, input logic uns,
                           input logic [1:0] lo, input logic [31:0] data);
        issue(2'd1, rd, 32'h0, size, uns, lo);
        cyc();
        in_valid = 0;
        check("load_busy_ready", 64'(in_ready), 64'd0);
        cyc();
        cyc();
        mem_rvalid = 1; mem_rdata = data;
        cyc();
        mem_rvalid = 0;
    endtask

    initial begin
        rst = 0; in_valid = 1; in_rd_en = 1; in_rd_addr = 5'd3; in_sel = 2'd0;
        in_alu_result = 32'h1111_2222; in_pc_plus4 = 32'h0; in_load_size = 2'd0;
        in_load_unsigned = 0; in_addr_lo = 2'd0; mem_rvalid = 0; mem_rdata = 32'h0;
        cyc();
        cyc();
        check("rst_we", 64'(rd_we), 64'd0);
        check("rst_ready", 64'(in_ready), 64'd1);
        check("rst_wdata", 64'(rd_wdata), 64'd0);
        check("rst_flags", 64'({err_misalign, err_unexp_rvalid}), 64'd0);
        rst = 1;

        issue(2'd0, 5'd5, 32'hDEADBEEF, 2'd0, 0, 2'd0);
        cyc();
        check("alu1_we", 64'(rd_we), 64'd1);
        check("alu1_addr", 64'(rd_addr), 64'd5);
        check("alu1_data", 64'(rd_wdata), 64'hDEADBEEF);
        issue(2'd0, 5'd6, 32'h12345678, 2'd0, 0, 2'd0);
        cyc();
        check("alu2_we", 64'(rd_we), 64'd1);
        check("alu2_addr", 64'(rd_addr), 64'd6);
        check("alu2_data", 64'(rd_wdata), 64'h12345678);
        in_valid = 0;
        cyc();
        check("alu_we_drop", 64'(rd_we), 64'd0);

        do_load(5'd7, 2'd0, 0, 2'd3, 32'h80FF0011);
        check("lb_we", 64'(rd_we), 64'd1);
        check("lb_addr", 64'(rd_addr), 64'd7);
        check("lb_data", 64'(rd_wdata), 64'hFFFFFF80);
        check("lb_ready", 64'(in_ready), 64'd1);
        do_load(5'd7, 2'd0, 1, 2'd3, 32'h80FF0011);
        check("lbu_data", 64'(rd_wdata), 64'h00000080);

        do_load(5'd8, 2'd1, 0, 2'd2, 32'h9ABC1234);
        check("lh_data", 64'(rd_wdata), 64'hFFFF9ABC);
        check("lh_mis", 64'(err_misalign), 64'd0);
        do_load(5'd8, 2'd1, 0, 2'd1, 32'h9ABC1234);
        check("lh_mis_data", 64'(rd_wdata), 64'h00001234);
        check("lh_mis_we", 64'(rd_we), 64'd1);
        check("lh_mis_flag", 64'(err_misalign), 64'd1);
        do_load(5'd9, 2'd3, 1, 2'd0, 32'hCAFEF00D);
        check("lw11_data", 64'(rd_wdata), 64'hCAFEF00D);

        issue(2'd0, 5'd0, 32'hFFFFFFFF, 2'd0, 0, 2'd0);
        cyc();
        check("x0_we", 64'(rd_we), 64'd0);
        issue(2'd2, 5'd1, 32'h00000104, 2'd0, 0, 2'd0);
        cyc();
        check("jal_we", 64'(rd_we), 64'd1);
        check("jal_data", 64'(rd_wdata), 64'h00000104);
        issue(2'd3, 5'd4, 32'h5555AAAA, 2'd0, 0, 2'd0);
        cyc();
        check("none_we", 64'(rd_we), 64'd0);
        in_valid = 0;

        issue(2'd1, 5'd10, 32'h0, 2'd2, 0, 2'd0);
        cyc();
        in_valid = 0;
        cyc();
        rst = 0;
        cyc();
        check("midrst_we", 64'(rd_we), 64'd0);
        check("midrst_ready", 64'(in_ready), 64'd1);
        check("midrst_mis", 64'(err_misalign), 64'd0);
        rst = 1;
        cyc();
        mem_rvalid = 1; mem_rdata = 32'h77777777;
        cyc();
        mem_rvalid = 0;
        check("late_rv_we", 64'(rd_we), 64'd0);
        check("late_rv_flag", 64'(err_unexp_rvalid), 64'd1);
        check("late_rv_ready", 64'(in_ready), 64'd1);
        cyc();

        for (int i = 0; i < 3000; i++) begin
            rst              = ($urandom_range(0, 99) != 0);
            in_valid         = $urandom_range(0, 1) == 1;
            in_rd_en         = $urandom_range(0, 7) != 0;
            in_rd_addr       = 5'($urandom_range(0, 31));
            in_sel           = 2'($urandom_range(0, 3));
            in_alu_result    = $urandom;
            in_pc_plus4      = $urandom;
            in_load_size     = 2'($urandom_range(0, 3));
            in_load_unsigned = $urandom_range(0, 1) == 1;
            in_addr_lo       = 2'($urandom_range(0, 3));
            mem_rvalid       = $urandom_range(0, 2) == 0;
            mem_rdata        = $urandom;
            cyc();
        end
        rst = 1; in_valid = 0; mem_rvalid = 0;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
